uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: takes a parallel byte on a request strobe and shifts it out on a single line as 8N1 (one start bit, eight data bits LSB first, one stop bit). It is the transmit side of the FPGA-to-PC link, driving the PC's RX pin and pairing with the existing UART receiver. It has its own baud divider and a one-byte holding register so that back-to-back bytes go out with no idle gap.

## Interface
- CLKS_PER_BIT, default 5208 (50 MHz / 9600 baud): clock cycles per serial bit. Legal range is 2 or more.

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- dataIn  in  8  byte to transmit; sampled only when a request is accepted
- send  in  1  transmit request, level-sampled each cycle
- ready  out  1  holding register empty; a request is accepted only when ready=1
- busy  out  1  a frame is being shifted out (state is not IDLE)
- finish  out  1  one-cycle pulse after each completed stop bit
- txd  out  1  serial line; idles high

## Operation
- State machine: IDLE, START, DATA, STOP.
- A bit timer counts 0 to CLKS_PER_BIT-1. A 3-bit index counts data bits 0 to 7. A shift register holds the byte in flight.
- Accept condition is `send && ready`, where `ready = !holdValid`. While ready=0, `send` is ignored and dataIn is not sampled.
- Accept while in IDLE, or in the last cycle of STOP with holdValid=0:
  - shift register loads dataIn directly; state goes to START and the bit timer clears.
  - ready stays 1.
- Accept in any other non-IDLE cycle: hold loads dataIn, holdValid goes to 1, and ready is 0 from the next cycle.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - txd = shift[0] for each bit.
  - At the end of each bit, the register shifts right and the index increments.
  - After bit 7, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. At the end:
  - finish pulses.
  - If holdValid=1: shift loads hold, holdValid clears, state goes to START. No idle cycles between frames.
  - Otherwise, if a new request is accepted in that cycle, go to START; else go to IDLE.
- txd, busy, ready and finish are registered outputs; no combinational paths from the inputs.
- Timer width is clog2(CLKS_PER_BIT). Index wrap is not used, because the state changes after bit 7.

## Timing
- Reset values: txd=1, ready=1, busy=0, finish=0, state=IDLE, holdValid=0. Timer, index, shift and hold are all 0.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). The frame in flight and any held byte are discarded.
- Request accepted on edge N: txd=0 and busy=1 from edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles: start, bit0..bit7, stop.
- finish is high for exactly one cycle, beginning at edge N+1+10×CLKS_PER_BIT. That is the same edge at which txd begins the next start bit, or at which busy falls to 0.
- Back-to-back frames: the next start bit's falling edge follows the previous stop bit with no extra cycle. ready returns to 1 on the same edge the held byte enters START.

## Test plan
All scenarios use CLKS_PER_BIT=4.

1. Reset idle:
   - Assert reset for 3 cycles, release, then wait 20 cycles with send=0.
   - Required: txd=1, ready=1, busy=0, finish=0 throughout.
2. Single frame:
   - send=1 for one cycle with dataIn=0xA5.
   - Required: txd shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   - busy is high for 40 cycles; finish pulses once at cycle 41 after the accept edge.
3. Back-to-back:
   - Send 0x55, then 0x0F 5 cycles later.
   - Required: ready=0 from the second accept until the second frame starts.
   - 80 contiguous frame cycles with no idle-high gap between the stop and start bits; two finish pulses 40 cycles apart.
4. Overflow:
   - While holdValid=1, pulse send with 0xFF.
   - Required: request ignored; only 0x55 and 0x0F are transmitted.
5. Reset mid-frame:
   - Assert reset at cycle 17 of a 0x3C frame.
   - Required: txd=1, busy=0, ready=1 immediately.
   - After release, send 0xC3; required: a clean 40-cycle frame.
6. Loopback:
   - Connect txd to the team's UART receiver running at the same baud rate; send 0x00, 0xFF, 0x3C.
   - Required: the receiver outputs exactly 0x00, 0xFF, 0x3C in order, with no framing errors.

Source files
------------

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// Handshake: a byte is taken on any rising edge where send=1 and ready=1;
// send while ready=0 is dropped and data_in is not looked at.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       send;
  logic       ready;
  logic       busy;
  logic       finish;
  logic       txd;
  logic [1:0] dbg_state;

  modport master (
    output data_in, send,
    input  ready, busy, finish, txd, dbg_state
  );

  modport slave (
    input  data_in, send,
    output ready, busy, finish, txd, dbg_state
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with its own baud timer and a one-byte holding
// register so back-to-back bytes leave with no idle gap on the line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic       clk,
  input logic       reset,
  uart_tx_if.slave  bus
);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      hold, hold_n;
  logic            hold_valid, hold_valid_n;
  logic            stop_end;
  logic            txd_q, busy_q, ready_q, finish_q;
  logic            txd_c;
  logic            accept;
  logic            bit_end;

  assign accept  = bus.send && !hold_valid;
  assign bit_end = (timer == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      stop_end   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      finish_q   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      idx        <= idx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      // Line outputs trail the state by one cycle; finish needs a second
      // stage so it lands on the edge the next start bit (or idle) appears.
      stop_end   <= (state == STOP) && bit_end;
      finish_q   <= stop_end;
      txd_q      <= txd_c;
      busy_q     <= (state != IDLE);
      ready_q    <= !hold_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    timer_n      = bit_end ? '0 : timer + TW'(1);
    idx_n        = idx;
    shift_n      = shift;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    txd_c        = 1'b1;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (accept) begin
          shift_n = bus.data_in;
          state_n = START;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (bit_end) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        txd_c = shift[0];
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (hold_valid) begin
            shift_n      = hold;
            hold_valid_n = 1'b0;
            state_n      = START;
          end else if (accept) begin
            shift_n = bus.data_in;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A request mid-frame parks in the holding register.
    if (accept && (state != IDLE) && !((state == STOP) && bit_end)) begin
      hold_n       = bus.data_in;
      hold_valid_n = 1'b1;
    end
  end

  assign bus.txd       = txd_q;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;
  assign bus.finish    = finish_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: timeline reference model of frames on the line, a
// sampling receiver on txd, fixed frame vectors and randomized traffic.
module tb_uart_tx;
  localparam int C = 4;

  logic clk;
  logic reset;
  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: frame timeline in edge numbers.
  int         cyc = 0;        // number of the next rising edge
  int         fa = -1;        // edge on which the current frame was accepted
  logic [7:0] fb = '0;        // byte of the current frame
  logic [7:0] hb = '0;        // held byte
  bit         hv = 0;         // held byte valid
  int         fin_edge = -1;  // edge after which finish must be high
  logic [7:0] exp_q[$];       // bytes expected on the line, in order

  int busy_cnt;
  int fin_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[k];
  endfunction

  function automatic void start_frame(input int e, input logic [7:0] b);
    fa = e;
    fb = b;
    exp_q.push_back(b);
  endfunction

  function automatic void model_step(input logic snd, input logic [7:0] d);
    bit acc, done;
    acc  = snd && !hv;
    done = (fa >= 0) && (cyc == fa + 10 * C);
    if (done) fin_edge = cyc + 1;
    if (done && hv) begin
      start_frame(cyc, hb);
      hv = 0;
    end else if (acc && (fa < 0 || done)) begin
      start_frame(cyc, d);
    end else if (done) begin
      fa = -1;
    end else if (acc) begin
      hb = d;
      hv = 1;
    end
  endfunction

  function automatic void model_reset();
    fa = -1;
    hv = 0;
    fin_edge = -1;
    exp_q.delete();
  endfunction

  // One clock: predict, advance the model, then compare after the edge.
  task automatic cycle();
    logic et, eb, ef, er;
    eb = (fa >= 0);
    et = eb ? frame_bit(fb, (cyc - 1 - fa) / C) : 1'b1;
    ef = (fin_edge == cyc);
    model_step(bus.send, bus.data_in);
    er = !hv;
    @(posedge clk);
    #1;
    check("txd", bus.txd, et);
    check("busy", bus.busy, eb);
    check("finish", bus.finish, ef);
    check("ready", bus.ready, er);
    if (bus.busy) busy_cnt++;
    if (bus.finish) fin_q.push_back(cyc);
    cyc++;
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    check("rst_txd", bus.txd, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_finish", bus.finish, 1'b0);
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.send    = 1'b1;
    bus.data_in = b;
    cycle();
    bus.send    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Sampling receiver on the line: mid-bit samples, framing check, scoreboard.
  initial begin
    bit         rbusy;
    int         cnt;
    logic [7:0] rb;
    rbusy = 0;
    cnt   = 0;
    rb    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rbusy = 0;
      end else if (!rbusy) begin
        if (bus.txd == 1'b0) begin
          rbusy = 1;
          cnt   = 0;
        end
      end else begin
        cnt++;
        if (cnt == C / 2) begin
          check("rx_start", bus.txd, 1'b0);
        end else if (cnt > C && cnt < 9 * C && (cnt % C) == C / 2) begin
          rb[cnt / C - 1] = bus.txd;
        end else if (cnt == 9 * C + C / 2) begin
          check("rx_stop", bus.txd, 1'b1);
          if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
          end else begin
            check("rx_byte", rb, exp_q.pop_front());
          end
          rbusy = 0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;  // line bits, [0] is the start bit
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, bits: 10'b1101001010};
    vecs[1] = '{data: 8'h00, bits: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, bits: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, bits: 10'b1001111000};
    vecs[4] = '{data: 8'h01, bits: 10'b1000000010};

    reset       = 1'b1;
    bus.send    = 1'b0;
    bus.data_in = '0;
    model_reset();
    for (int i = 0; i < 3; i++) rst_cycle();
    reset = 1'b0;
    idle(20);

    // Single frames from the vector table; includes 0xA5 and the loopback bytes.
    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].data);
      for (int j = 0; j < 10 * C; j++) begin
        cycle();
        if ((j % C) == C / 2) check("vec_bit", bus.txd, vecs[v].bits[j / C]);
      end
      cycle();
      check("vec_finish41", bus.finish, 1'b1);
      idle(3);
    end

    // Back-to-back with an overflow attempt while the holding register is full.
    busy_cnt = 0;
    fin_q.delete();
    send_byte(8'h55);
    idle(4);
    send_byte(8'h0F);
    check("b2b_ready_low", bus.ready, 1'b0);
    idle(10);
    send_byte(8'hFF);
    idle(100);
    check("b2b_busy_cycles", busy_cnt, 80);
    check("b2b_fin_count", fin_q.size(), 2);
    if (fin_q.size() == 2) check("b2b_fin_gap", fin_q[1] - fin_q[0], 40);
    check("b2b_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h3C);
    idle(16);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_txd", bus.txd, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.ready, 1'b1);
    model_reset();
    for (int i = 0; i < 2; i++) rst_cycle();
    reset = 1'b0;
    busy_cnt = 0;
    send_byte(8'hC3);
    idle(45);
    check("post_rst_busy", busy_cnt, 40);

    // Randomized traffic against the model.
    for (int i = 0; i < 700; i++) begin
      bus.send    = ($urandom_range(0, 9) == 0);
      bus.data_in = 8'($urandom_range(0, 255));
      cycle();
    end
    bus.send = 1'b0;
    idle(100);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout edge=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
